// File: rtl/fp_divider.sv
// fp_divider: iterative floating-point divider, result = X / Y.
// Sign/exponent/fraction format with implicit leading one, no denormals,
// truncated (unrounded) results. The mantissa quotient is produced by a
// restoring divider, one bit per clock, behind a start/busy/done handshake.
// Status flags zero/underflow/overflow/nan mirror the companion multiplier.
module fp_divider #(
    parameter int E = 8,
    parameter int M = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [E+M:0] X,
    input  logic [E+M:0] Y,
    output logic         busy,
    output logic         done,
    output logic [E+M:0] result,
    output logic         zero,
    output logic         underflow,
    output logic         overflow,
    output logic         nan
);

    localparam int CW = $clog2(M + 3);
    localparam logic [CW-1:0]       CNT_INIT = CW'(M + 2);
    localparam logic [CW-1:0]       CNT_LAST = CW'(1);
    localparam logic signed [E+1:0] BIAS     = (E+2)'((1 << (E - 1)) - 1);
    localparam logic signed [E+1:0] EXP_MAX  = (E+2)'((1 << E) - 1);
    localparam logic signed [E+1:0] EXP_ONE  = (E+2)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [E+M:0]        r_x;
    logic [E+M:0]        r_y;
    logic                r_sign;
    logic signed [E+1:0] r_exp;
    logic [M+2:0]        r_rem;
    logic [M+1:0]        r_div;
    logic [M+1:0]        r_q;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [E+M:0]        r_result;
    logic                r_zero;
    logic                r_underflow;
    logic                r_overflow;
    logic                r_nan;

    // Operand fields and classes of the latched operands
    logic [E-1:0]        w_ex;
    logic [E-1:0]        w_ey;
    logic [M-1:0]        w_fx;
    logic [M-1:0]        w_fy;
    logic                w_sign;
    logic                w_x_zero;
    logic                w_y_zero;
    logic                w_x_inf;
    logic                w_y_inf;
    logic                w_x_nan;
    logic                w_y_nan;
    logic signed [E+1:0] w_exp_prep;

    assign w_ex     = r_x[E+M-1:M];
    assign w_ey     = r_y[E+M-1:M];
    assign w_fx     = r_x[M-1:0];
    assign w_fy     = r_y[M-1:0];
    assign w_sign   = r_x[E+M] ^ r_y[E+M];
    assign w_x_zero = (w_ex == '0);
    assign w_y_zero = (w_ey == '0);
    assign w_x_inf  = (&w_ex) && (w_fx == '0);
    assign w_y_inf  = (&w_ey) && (w_fy == '0);
    assign w_x_nan  = (&w_ex) && (w_fx != '0);
    assign w_y_nan  = (&w_ey) && (w_fy != '0);

    // Biased quotient exponent; two guard bits keep the full range signed
    assign w_exp_prep = $signed({2'b00, w_ex}) - $signed({2'b00, w_ey}) + BIAS;

    // Special-case detection and the result/flags it produces
    logic         w_special;
    logic [E+M:0] w_sp_result;
    logic [3:0]   w_sp_flags;   // {zero, underflow, overflow, nan}

    // Pick the special result by priority: invalid, then infinite, then zero
    always_comb begin
        w_special   = 1'b1;
        w_sp_result = '0;
        w_sp_flags  = 4'b0000;
        if (w_x_nan || w_y_nan || (w_x_zero && w_y_zero) || (w_x_inf && w_y_inf)) begin
            w_sp_result = {w_sign, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            w_sp_flags  = 4'b0001;
        end else if (w_y_zero || w_x_inf) begin
            w_sp_result = {w_sign, {E{1'b1}}, {M{1'b0}}};
            w_sp_flags  = 4'b0010;
        end else if (w_x_zero || w_y_inf) begin
            w_sp_result = {w_sign, {(E+M){1'b0}}};
            w_sp_flags  = 4'b1000;
        end else begin
            w_special   = 1'b0;
        end
    end

    // One restoring-division step: subtract when the divisor fits, then shift
    logic         w_ge;
    logic [M+1:0] w_diff;
    logic [M+2:0] w_rem_next;
    logic [M+1:0] w_q_next;

    assign w_ge       = (r_rem >= {1'b0, r_div});
    // When w_ge holds the difference is below the divisor, so M+2 bits suffice
    assign w_diff     = r_rem[M+1:0] - r_div;
    assign w_rem_next = {(w_ge ? w_diff : r_rem[M+1:0]), 1'b0};
    assign w_q_next   = {r_q[M:0], w_ge};

    // Normalization: q lies in (0.5, 2), so at most one left shift is needed
    logic [M-1:0]        w_frac;
    logic signed [E+1:0] w_expf;
    logic [E+M:0]        w_nm_result;
    logic [3:0]          w_nm_flags;   // {zero, underflow, overflow, nan}

    assign w_frac = r_q[M+1] ? r_q[M:1] : r_q[M-1:0];
    assign w_expf = r_q[M+1] ? r_exp : (r_exp - EXP_ONE);

    // Range-check the normalized exponent and assemble the normal result
    always_comb begin
        w_nm_result = {r_sign, w_expf[E-1:0], w_frac};
        w_nm_flags  = 4'b0000;
        if (w_expf >= EXP_MAX) begin
            w_nm_result = {r_sign, {E{1'b1}}, {M{1'b0}}};
            w_nm_flags  = 4'b0010;
        end else if (w_expf <= 0) begin
            w_nm_result = {r_sign, {(E+M){1'b0}}};
            w_nm_flags  = 4'b0100;
        end
    end

    // Control FSM with registered handshake, result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_nan       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= X;
                        r_y     <= Y;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_sign <= w_sign;
                    r_exp  <= w_exp_prep;
                    r_rem  <= {2'b00, 1'b1, w_fx};
                    r_div  <= {1'b1, w_fy};
                    r_q    <= '0;
                    r_cnt  <= CNT_INIT;
                    if (w_special) begin
                        r_result <= w_sp_result;
                        {r_zero, r_underflow, r_overflow, r_nan} <= w_sp_flags;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CNT_LAST;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_result <= w_nm_result;
                    {r_zero, r_underflow, r_overflow, r_nan} <= w_nm_flags;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign zero      = r_zero;
    assign underflow = r_underflow;
    assign overflow  = r_overflow;
    assign nan       = r_nan;

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed and random checks of fp_divider against an
// arithmetic reference model; two instances (E=8/M=23 and E=6/M=16).
module tb_fp_divider;

    logic        clk;
    logic        reset;

    logic        st8, busy8, done8, z8, u8, o8, n8;
    logic [31:0] x8, y8, r8;
    logic        st6, busy6, done6, z6, u6, o6, n6;
    logic [22:0] x6, y6, r6;

    int n_vec;
    int n_fail;

    fp_divider #(.E(8), .M(23)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .X(x8), .Y(y8),
        .busy(busy8), .done(done8), .result(r8),
        .zero(z8), .underflow(u8), .overflow(o8), .nan(n8)
    );

    fp_divider #(.E(6), .M(16)) dut6 (
        .clk(clk), .reset(reset), .start(st6), .X(x6), .Y(y6),
        .busy(busy6), .done(done6), .result(r6),
        .zero(z6), .underflow(u6), .overflow(o6), .nan(n6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: classify, divide the full significands as integers, normalize
    function automatic void model(input int e, input int m, input longint x, input longint y,
                                  output longint res, output logic [3:0] fl, output int lat);
        longint one, emax, bias, fmask, s, ex, ey, fx, fy, q, ef, frac;
        bit xz, yz, xi, yi, xn, yn;
        one   = 1;
        emax  = (one << e) - 1;
        bias  = (one << (e - 1)) - 1;
        fmask = (one << m) - 1;
        s  = ((x >> (e + m)) ^ (y >> (e + m))) & 1;
        ex = (x >> m) & emax;
        ey = (y >> m) & emax;
        fx = x & fmask;
        fy = y & fmask;
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == emax) && (fx == 0);
        yi = (ey == emax) && (fy == 0);
        xn = (ex == emax) && (fx != 0);
        yn = (ey == emax) && (fy != 0);
        lat = 2;
        fl  = 4'b0000;
        res = 0;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            res = (s << (e + m)) | (emax << m) | (one << (m - 1));
            fl  = 4'b0001;
        end else if (yz || xi) begin
            res = (s << (e + m)) | (emax << m);
            fl  = 4'b0010;
        end else if (xz || yi) begin
            res = s << (e + m);
            fl  = 4'b1000;
        end else begin
            lat = m + 5;
            q   = (((one << m) | fx) << (m + 1)) / ((one << m) | fy);
            ef  = ex - ey + bias;
            if (q >= (one << (m + 1))) begin
                frac = (q >> 1) & fmask;
            end else begin
                frac = q & fmask;
                ef   = ef - 1;
            end
            if (ef >= emax) begin
                res = (s << (e + m)) | (emax << m);
                fl  = 4'b0010;
            end else if (ef <= 0) begin
                res = s << (e + m);
                fl  = 4'b0100;
            end else begin
                res = (s << (e + m)) | (ef << m) | frac;
            end
        end
    endfunction

    // Random operand biased toward normals, with occasional zero/inf/NaN
    function automatic longint rnd_op(input int e, input int m);
        longint one, emax, f, s, ex;
        int k;
        one  = 1;
        emax = (one << e) - 1;
        k    = $urandom_range(0, 15);
        s    = longint'($urandom_range(0, 1));
        f    = longint'($urandom) & ((one << m) - 1);
        if (k == 0)      ex = 0;
        else if (k == 1) begin ex = emax; f = 0; end
        else if (k == 2) begin ex = emax; f = f | 1; end
        else             ex = longint'($urandom_range(1, 32'(emax - 1)));
        return (s << (e + m)) | (ex << m) | f;
    endfunction

    // One operation: start, optional stray start at cycle 'poke', check outputs
    task automatic run(input int sel, input longint x, input longint y, input int poke, input string tag);
        longint    er;
        logic [3:0] ef;
        int        el, cyc, bcnt;
        bit        got;
        logic      d, b;
        logic [63:0] res_o;
        logic [3:0]  fl_o;
        model((sel == 0) ? 8 : 6, (sel == 0) ? 23 : 16, x, y, er, ef, el);
        @(negedge clk);
        if (sel == 0) begin x8 = 32'(x); y8 = 32'(y); st8 = 1'b1; end
        else          begin x6 = 23'(x); y6 = 23'(y); st6 = 1'b1; end
        @(posedge clk);
        #1;
        st8 = 1'b0;
        st6 = 1'b0;
        cyc  = 0;
        bcnt = 0;
        got  = 0;
        while (cyc < 100) begin
            d = (sel == 0) ? done8 : done6;
            b = (sel == 0) ? busy8 : busy6;
            if (d) begin
                got = 1;
                break;
            end
            if (b) bcnt++;
            if (cyc == poke) begin
                if (sel == 0) begin x8 = ~x8; y8 = ~y8; st8 = 1'b1; end
                else          begin x6 = ~x6; y6 = ~y6; st6 = 1'b1; end
            end else begin
                st8 = 1'b0;
                st6 = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        st8 = 1'b0;
        st6 = 1'b0;
        if (!got) check({tag, " done timeout"}, 64'(got), 64'd1);
        res_o = (sel == 0) ? 64'(r8) : 64'(r6);
        fl_o  = (sel == 0) ? {z8, u8, o8, n8} : {z6, u6, o6, n6};
        check({tag, " latency"}, 64'(cyc), 64'(el));
        check({tag, " busy cycles"}, 64'(bcnt), 64'(el));
        check({tag, " result"}, res_o, 64'(er));
        check({tag, " flags zuon"}, 64'(fl_o), 64'(ef));
    endtask

    int dcnt;

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        st8 = 1'b0; x8 = '0; y8 = '0;
        st6 = 1'b0; x6 = '0; y6 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy8), 64'd0);
        check("reset done", 64'(done8), 64'd0);
        check("reset result", 64'(r8), 64'd0);
        check("reset flags", 64'({z8, u8, o8, n8}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors (E=8, M=23)
        run(0, 64'h40C00000, 64'h40000000, -1, "6/2");
        check("6/2 value", 64'(r8), 64'h40400000);
        run(0, 64'h3F800000, 64'h40400000, -1, "1/3");
        check("1/3 value", 64'(r8), 64'h3EAAAAAA);
        run(0, 64'hBFC00000, 64'h3F000000, -1, "-1.5/0.5");
        check("-1.5/0.5 value", 64'(r8), 64'hC0400000);
        run(0, 64'h00000000, 64'h00000000, -1, "0/0");
        check("0/0 value", 64'(r8), 64'h7FC00000);
        run(0, 64'h3F800000, 64'h00000000, -1, "1/0");
        check("1/0 value", 64'(r8), 64'h7F800000);
        run(0, 64'h00000000, 64'h40000000, -1, "0/2");
        check("0/2 flags", 64'({z8, u8, o8, n8}), 64'b1000);
        run(0, 64'h7F000000, 64'h3E800000, -1, "ovf");
        check("ovf flags", 64'({z8, u8, o8, n8}), 64'b0010);
        run(0, 64'h00800000, 64'h40000000, -1, "unf");
        check("unf flags", 64'({z8, u8, o8, n8}), 64'b0100);
        run(0, 64'hFF800000, 64'h7F800000, -1, "inf/inf");
        run(0, 64'h7FC00001, 64'h3F800000, -1, "nan/1");

        // Stray start during DIV and during DONE must be ignored
        run(0, 64'h40490FDB, 64'h402DF854, 5, "poke div");
        run(0, 64'h3F800000, 64'h3F800000, 27, "poke done");
        run(0, 64'h3F800000, 64'h00000000, 1, "poke special");

        // Reset pulsed at cycle 10 of a normal divide aborts it
        @(negedge clk);
        x8 = 32'h40C00000; y8 = 32'h40000000; st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", 64'(busy8), 64'd0);
        check("abort result", 64'(r8), 64'd0);
        check("abort flags", 64'({z8, u8, o8, n8}), 64'd0);
        dcnt = 0;
        repeat (40) begin
            if (done8) dcnt++;
            @(posedge clk);
            #1;
        end
        check("abort no done", 64'(dcnt), 64'd0);
        run(0, 64'h40C00000, 64'h40000000, -1, "after abort");

        // reset and start on the same edge: start is dropped
        @(negedge clk);
        reset = 1'b1; st8 = 1'b1; x8 = 32'h40000000; y8 = 32'h3F800000;
        @(posedge clk);
        #1;
        reset = 1'b0; st8 = 1'b0;
        check("reset+start busy", 64'(busy8), 64'd0);
        @(posedge clk);
        #1;
        check("reset+start idle", 64'(busy8), 64'd0);

        // Second instance E=6, M=16: 2.0 / 1.0 (exponents 32 and 31, bias 31)
        run(1, 64'h200000, 64'h1F0000, -1, "e6 2/1");
        check("e6 2/1 value", 64'(r6), 64'h200000);
        run(1, 64'h1F0000, 64'h208000, -1, "e6 1/3");

        // Random vectors, back-to-back, on both instances
        for (int i = 0; i < 30; i++) begin
            run(0, rnd_op(8, 23), rnd_op(8, 23), -1, "rnd8");
        end
        for (int i = 0; i < 12; i++) begin
            run(1, rnd_op(6, 16), rnd_op(6, 16), -1, "rnd6");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
